// File: rtl/errlog_pkg.sv
// errlog_pkg: shared types and constants for the multi-source error logger.
//   log_t       : one FIFO entry {sev, code, src_id, d0, d1[, ts]}
//   REG_*       : APB register byte offsets
//   IRQ_*       : bit positions in IRQ_EN / IRQ_STAT
//   sev_class() : maps a severity to info / recoverable / fatal
// Optional feature macro: ERRLOG_TIMESTAMP_EN adds a 32-bit timestamp per entry.
package errlog_pkg;

  typedef struct packed {
    logic [3:0]  sev;
    logic [7:0]  code;
    logic [3:0]  src;
    logic [31:0] d0;
    logic [31:0] d1;
`ifdef ERRLOG_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } log_t;

  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_POP    = 8'h04;
  localparam logic [7:0] REG_HEAD   = 8'h08;
  localparam logic [7:0] REG_D0     = 8'h0C;
  localparam logic [7:0] REG_D1     = 8'h10;
  localparam logic [7:0] REG_DROP   = 8'h14;
  localparam logic [7:0] REG_IRQ_EN = 8'h18;
  localparam logic [7:0] REG_IRQ_ST = 8'h1C;
  localparam logic [7:0] REG_TSTAMP = 8'h20;

  localparam int IRQ_REC   = 0;
  localparam int IRQ_FATAL = 1;

  typedef enum logic [1:0] {
    CLS_INFO  = 2'd0,
    CLS_REC   = 2'd1,
    CLS_FATAL = 2'd2
  } sev_cls_e;

  // Severity 0 is informational and never raises an interrupt.
  function automatic sev_cls_e sev_class(input logic [3:0] sev, input int fatal_sev);
    if (sev == 4'd0) return CLS_INFO;
    if (int'(sev) >= fatal_sev) return CLS_FATAL;
    return CLS_REC;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts at the stored pointer.
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request
//   advance    : winner was accepted this cycle; pointer moves past it
//   gnt        : one-hot (or zero) grant, combinational from req/pointer
//   idx        : binary index of the grant (0 when none)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_q) + i) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

  // Pointer only moves on an accepted grant, so a stalled winner keeps priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(idx) == N - 1) ? '0 : idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/error_logger_mc.sv
// error_logger_mc: multi-source error logger with APB drain port.
//   clk, rst_n                 : clock, async active-low reset
//   evt_valid/evt_ready        : per-channel event handshake (ready one-hot or zero)
//   evt_severity/code/data0/1  : packed per-channel event fields
//   psel/penable/pwrite/paddr/pwdata : APB request
//   prdata/pready/pslverr      : APB response, one wait state, pready is a 1-cycle pulse
//   irq_fatal/irq_recoverable  : level interrupts, IRQ_STAT & IRQ_EN
// Optional feature macro: ERRLOG_TIMESTAMP_EN stores a free-running cycle count
// with every entry and exposes the head's value at TSTAMP.
module error_logger_mc
  import errlog_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DEPTH        = 32,
  parameter int FATAL_SEV    = 3,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC-1:0]    evt_valid,
  output logic [N_SRC-1:0]    evt_ready,
  input  logic [N_SRC*4-1:0]  evt_severity,
  input  logic [N_SRC*8-1:0]  evt_code,
  input  logic [N_SRC*32-1:0] evt_data0,
  input  logic [N_SRC*32-1:0] evt_data1,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [7:0]          paddr,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                irq_fatal,
  output logic                irq_recoverable
);

  localparam int DW = $clog2(DEPTH);
  localparam int CW = DW + 1;
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             accept, full, empty, push, drop, pop;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  log_t             mem_q [DEPTH];
  log_t             wr_entry, head;
  sev_cls_e         cls;

  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [1:0]       irq_en_q, irq_en_d, irq_stat_q, irq_stat_d, irq_set;

  logic             pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0]      prdata_q, prdata_d, rd_val;
  logic             apb_acc, acc_err, wr_pop, wr_clr, wr_en, wr_w1c;

  logic             unused_pwdata;
  assign unused_pwdata = ^pwdata[31:2];

`ifdef ERRLOG_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  assign ts_d = ts_q + 32'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end
`endif

  // ---------------- arbitration / push side ----------------
  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (evt_valid),
    .advance (accept),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  // full is registered, so ready never depends on a same-cycle pop.
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign evt_ready = gnt & {N_SRC{~full | (DROP_ON_FULL != 0)}};
  assign accept    = |evt_ready;
  assign push      = accept & ~full;
  assign drop      = accept & full;

  always_comb begin
    wr_entry     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        wr_entry.sev  = evt_severity[i*4 +: 4];
        wr_entry.code = evt_code[i*8 +: 8];
        wr_entry.d0   = evt_data0[i*32 +: 32];
        wr_entry.d1   = evt_data1[i*32 +: 32];
      end
    end
    wr_entry.src = 4'(gnt_idx);
`ifdef ERRLOG_TIMESTAMP_EN
    wr_entry.ts  = ts_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  // ---------------- APB decode ----------------
  // The access is committed on the cycle it is first seen; pready follows.
  always_comb begin
    apb_acc = psel & penable & ~pready_q;
    rd_val  = '0;
    acc_err = 1'b0;
    wr_pop  = 1'b0;
    wr_clr  = 1'b0;
    wr_en   = 1'b0;
    wr_w1c  = 1'b0;
    case (paddr)
      REG_STATUS: if (pwrite) acc_err = 1'b1;
                  else rd_val = (32'(cnt_q) << 8) | {30'd0, full, empty};
      REG_POP:    if (pwrite) wr_pop = 1'b1; else acc_err = 1'b1;
      REG_HEAD:   if (pwrite) acc_err = 1'b1;
                  else rd_val = {4'd0, head.sev, head.code, 12'd0, head.src};
      REG_D0:     if (pwrite) acc_err = 1'b1; else rd_val = head.d0;
      REG_D1:     if (pwrite) acc_err = 1'b1; else rd_val = head.d1;
      REG_DROP:   if (pwrite) wr_clr = 1'b1; else rd_val = 32'(drop_cnt_q);
      REG_IRQ_EN: if (pwrite) wr_en  = 1'b1; else rd_val = {30'd0, irq_en_q};
      REG_IRQ_ST: if (pwrite) wr_w1c = 1'b1; else rd_val = {30'd0, irq_stat_q};
`ifdef ERRLOG_TIMESTAMP_EN
      REG_TSTAMP: if (pwrite) acc_err = 1'b1; else rd_val = head.ts;
`else
      REG_TSTAMP: if (pwrite) acc_err = 1'b1;
`endif
      default:    acc_err = 1'b1;
    endcase
    pready_d  = apb_acc;
    pslverr_d = apb_acc & acc_err;
    prdata_d  = (apb_acc && !acc_err) ? rd_val : '0;
  end

  // ---------------- FIFO / register next state ----------------
  assign pop = apb_acc & wr_pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + DW'(push);
    rd_ptr_d = rd_ptr_q + DW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (apb_acc && wr_clr) drop_cnt_d = '0;
    if (drop && drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  // Dropped events still raise status; a new event beats a same-cycle W1C.
  always_comb begin
    cls                = sev_class(wr_entry.sev, FATAL_SEV);
    irq_set            = '0;
    irq_set[IRQ_FATAL] = accept && (cls == CLS_FATAL);
    irq_set[IRQ_REC]   = accept && (cls == CLS_REC);
    irq_stat_d         = irq_stat_q;
    if (apb_acc && wr_w1c) irq_stat_d = irq_stat_q & ~pwdata[1:0];
    irq_stat_d         = irq_stat_d | irq_set;
    irq_en_d           = (apb_acc && wr_en) ? pwdata[1:0] : irq_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      irq_en_q   <= 2'b11;
      irq_stat_q <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  assign pready          = pready_q;
  assign pslverr         = pslverr_q;
  assign prdata          = prdata_q;
  assign irq_fatal       = irq_stat_q[IRQ_FATAL] & irq_en_q[IRQ_FATAL];
  assign irq_recoverable = irq_stat_q[IRQ_REC] & irq_en_q[IRQ_REC];

endmodule

// File: tb/tb_error_logger_mc.sv
// Bench for error_logger_mc: two instances (backpressure and drop policy) share
// stimulus; 'sel' chooses which one is checked against a queue-based model.
module tb_error_logger_mc;
  localparam int N = 4, DEPTH = 32;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    evt_valid;
  logic [N*4-1:0]  evt_severity;
  logic [N*8-1:0]  evt_code;
  logic [N*32-1:0] evt_data0, evt_data1;
  logic            psel, penable, pwrite;
  logic [7:0]      paddr;
  logic [31:0]     pwdata;

  logic [N-1:0] rdy0, rdy1;
  logic [31:0]  prd0, prd1;
  logic prdy0, prdy1, perr0, perr1, irqf0, irqf1, irqr0, irqr1;

  error_logger_mc #(.N_SRC(N), .DEPTH(DEPTH), .FATAL_SEV(3), .DROP_ON_FULL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(rdy0),
    .evt_severity(evt_severity), .evt_code(evt_code), .evt_data0(evt_data0), .evt_data1(evt_data1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prd0), .pready(prdy0), .pslverr(perr0), .irq_fatal(irqf0), .irq_recoverable(irqr0));

  error_logger_mc #(.N_SRC(N), .DEPTH(DEPTH), .FATAL_SEV(3), .DROP_ON_FULL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(rdy1),
    .evt_severity(evt_severity), .evt_code(evt_code), .evt_data0(evt_data0), .evt_data1(evt_data1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prd1), .pready(prdy1), .pslverr(perr1), .irq_fatal(irqf1), .irq_recoverable(irqr1));

  logic         sel;
  logic [N-1:0] evt_ready;
  logic [31:0]  prdata;
  logic         pready, pslverr, irq_fatal, irq_recoverable;
  assign evt_ready       = sel ? rdy1  : rdy0;
  assign prdata          = sel ? prd1  : prd0;
  assign pready          = sel ? prdy1 : prdy0;
  assign pslverr         = sel ? perr1 : perr0;
  assign irq_fatal       = sel ? irqf1 : irqf0;
  assign irq_recoverable = sel ? irqr1 : irqr0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] sev; logic [7:0] code; logic [3:0] src; logic [31:0] d0, d1;
  } ent_t;
  ent_t        q[$];
  int          m_ptr, m_drop_cnt;
  logic [1:0]  m_en, m_stat;
  bit          m_pready, m_err, rnd_evt;
  logic [31:0] m_rd, got_rd;
  logic        got_err;
  int          tot = 0, bad = 0;

  task automatic model_reset();
    q.delete(); m_ptr = 0; m_drop_cnt = 0; m_en = 2'b11; m_stat = 2'b00;
    m_pready = 0; m_err = 0; m_rd = '0;
  endtask

  // One clock: optional random events, check ready/irq, advance the model.
  task automatic step();
    int w; bit acc, full, commit, wr; logic [N-1:0] exp_rdy; logic [7:0] a; ent_t e;
    if (rnd_evt) begin
      for (int i = 0; i < N; i++) evt_valid[i] = ($urandom_range(0, 2) == 0);
      evt_severity = 16'($urandom);
      evt_code     = $urandom;
      evt_data0    = {$urandom, $urandom, $urandom, $urandom};
      evt_data1    = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    full = (q.size() == DEPTH);
    w = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (w < 0 && evt_valid[c]) w = c;
    end
    acc = (w >= 0) && (!full || sel);
    exp_rdy = acc ? N'(1 << w) : '0;
    tot++;
    if (evt_ready !== exp_rdy) begin
      bad++; $display("FAIL evt_ready t=%0t got=%b want=%b", $time, evt_ready, exp_rdy);
    end
    tot++;
    if ({irq_fatal, irq_recoverable} !== (m_stat & m_en)) begin
      bad++; $display("FAIL irq t=%0t got=%b want=%b", $time, {irq_fatal, irq_recoverable}, m_stat & m_en);
    end
    commit = psel && penable && !m_pready;
    a = paddr; wr = pwrite;
    if (commit) begin
      m_rd = '0; m_err = 0;
      case (a)
        8'h00: if (wr) m_err = 1;
               else m_rd = (32'(q.size()) << 8) + (full ? 32'd2 : 32'd0) + ((q.size() == 0) ? 32'd1 : 32'd0);
        8'h04: if (!wr) m_err = 1;
        8'h08: if (wr) m_err = 1;
               else if (q.size() > 0) m_rd = (32'(q[0].sev) << 24) + (32'(q[0].code) << 16) + 32'(q[0].src);
        8'h0C: if (wr) m_err = 1; else if (q.size() > 0) m_rd = q[0].d0;
        8'h10: if (wr) m_err = 1; else if (q.size() > 0) m_rd = q[0].d1;
        8'h14: if (!wr) m_rd = 32'(m_drop_cnt);
        8'h18: if (!wr) m_rd = 32'(m_en);
        8'h1C: if (!wr) m_rd = 32'(m_stat);
        8'h20: if (wr) m_err = 1;
        default: m_err = 1;
      endcase
    end
    @(posedge clk);
    if (commit && wr && !m_err) begin
      case (a)
        8'h04: if (q.size() > 0) void'(q.pop_front());
        8'h14: m_drop_cnt = 0;
        8'h18: m_en = pwdata[1:0];
        8'h1C: m_stat = m_stat & ~pwdata[1:0];
        default: ;
      endcase
    end
    if (acc) begin
      e.sev = evt_severity[w*4 +: 4]; e.code = evt_code[w*8 +: 8]; e.src = 4'(w);
      e.d0 = evt_data0[w*32 +: 32]; e.d1 = evt_data1[w*32 +: 32];
      if (!full) q.push_back(e);
      else if (m_drop_cnt < 65535) m_drop_cnt++;
      if (e.sev >= 3) m_stat[1] = 1'b1;
      else if (e.sev != 0) m_stat[0] = 1'b1;
      m_ptr = (w + 1) % N;
    end
    m_pready = commit;
    @(negedge clk);
  endtask

  task automatic apb_setup(input logic [7:0] a, input logic w, input logic [31:0] d);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    step();
  endtask

  task automatic apb_access(input string nm);
    penable = 1'b1;
    step();
    got_rd = prdata; got_err = pslverr;
    tot++;
    if (pready !== 1'b1) begin bad++; $display("FAIL %s pready got=%b want=1", nm, pready); end
    tot++;
    if (prdata !== m_rd) begin bad++; $display("FAIL %s prdata got=%h want=%h", nm, prdata, m_rd); end
    tot++;
    if (pslverr !== m_err) begin bad++; $display("FAIL %s pslverr got=%b want=%b", nm, pslverr, m_err); end
    psel = 1'b0; penable = 1'b0;
    step();
    tot++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      bad++; $display("FAIL %s idle got=%b/%b/%h want=0", nm, pready, pslverr, prdata);
    end
  endtask

  task automatic apb(input logic [7:0] a, input logic w, input logic [31:0] d, input string nm);
    apb_setup(a, w, d);
    apb_access(nm);
  endtask

  task automatic do_reset();
    evt_valid = '0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    rst_n = 1'b0;
    #1;
    tot++;
    if ({evt_ready, pready, pslverr, prdata, irq_fatal, irq_recoverable} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%b/%b/%h/%b%b want=0", evt_ready, pready, pslverr,
                      prdata, irq_fatal, irq_recoverable);
    end
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sel = 0; do_reset();
    apb(8'h00, 0, 0, "rst_status");
    tot++; if (got_rd !== 32'h1) begin bad++; $display("FAIL rst_status_const got=%h want=1", got_rd); end
    apb(8'h18, 0, 0, "rst_irq_en");
    apb(8'h1C, 0, 0, "rst_irq_stat");
    apb(8'h14, 0, 0, "rst_drop");
    apb(8'h08, 0, 0, "rst_head");
  endtask

  task automatic test_single();
    sel = 0; do_reset();
    evt_valid = 4'b0100;
    evt_severity = '0; evt_code = '0; evt_data0 = '0; evt_data1 = '0;
    evt_severity[8 +: 4] = 4'd3; evt_code[16 +: 8] = 8'h5A;
    evt_data0[64 +: 32] = 32'hDEAD; evt_data1[64 +: 32] = 32'h1234_5678;
    apb_setup(8'h08, 0, 0);           // event accepted on this edge
    evt_valid = '0;
    apb_access("head_next_cycle");    // head read committed the very next edge
    tot++; if (got_rd !== 32'h035A_0002) begin bad++; $display("FAIL head_const got=%h want=035a0002", got_rd); end
    apb(8'h0C, 0, 0, "d0");
    tot++; if (got_rd !== 32'hDEAD) begin bad++; $display("FAIL d0_const got=%h want=dead", got_rd); end
    apb(8'h10, 0, 0, "d1");
    tot++; if (irq_fatal !== 1'b1) begin bad++; $display("FAIL irq_fatal got=%b want=1", irq_fatal); end
  endtask

  task automatic test_rr();
    sel = 0; do_reset();
    evt_valid = 4'hF; evt_severity = '0;
    #1;
    for (int i = 0; i < 8; i++) begin
      tot++;
      if (evt_ready !== 4'(1 << (i % 4))) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, evt_ready, 4'(1 << (i % 4)));
      end
      step();
    end
    evt_valid = '0;
    apb(8'h00, 0, 0, "rr_status");
    tot++; if (got_rd !== 32'h800) begin bad++; $display("FAIL rr_count got=%h want=800", got_rd); end
  endtask

  task automatic test_backpressure();
    sel = 0; do_reset();
    evt_valid = 4'hF; evt_severity = 16'h1111;
    repeat (DEPTH) step();
    repeat (2) step();                // full: ready must stay low
    apb(8'h04, 1, 0, "bp_pop");       // idle step after pop refills the slot
    step();
    evt_valid = '0;
    apb(8'h00, 0, 0, "bp_status");
    tot++; if (got_rd !== 32'h2002) begin bad++; $display("FAIL bp_full got=%h want=2002", got_rd); end
  endtask

  task automatic test_drop();
    sel = 1; do_reset();
    evt_valid = 4'b0001; evt_severity = 16'h0001;
    repeat (DEPTH + 3) step();
    evt_valid = '0;
    apb(8'h14, 0, 0, "drop_cnt");
    tot++; if (got_rd !== 32'd3) begin bad++; $display("FAIL drop_cnt_const got=%h want=3", got_rd); end
    apb(8'h00, 0, 0, "drop_status");
    tot++; if (got_rd !== 32'h2002) begin bad++; $display("FAIL drop_count got=%h want=2002", got_rd); end
    apb(8'h14, 1, 0, "drop_clear");
    apb(8'h14, 0, 0, "drop_after_clear");
    tot++; if (got_rd !== 32'd0) begin bad++; $display("FAIL drop_clear_const got=%h want=0", got_rd); end
    sel = 0;
  endtask

  task automatic test_irq();
    sel = 0; do_reset();
    apb(8'h18, 1, 32'h1, "irq_en_wr");
    evt_valid = 4'b0001; evt_severity = 16'h0001; step();
    evt_valid = 4'b0010; evt_severity = 16'h0030; step();
    evt_valid = '0; step();
    tot++;
    if ({irq_fatal, irq_recoverable} !== 2'b01) begin
      bad++; $display("FAIL irq_levels got=%b want=01", {irq_fatal, irq_recoverable});
    end
    apb(8'h1C, 0, 0, "irq_stat");
    tot++; if (got_rd !== 32'h3) begin bad++; $display("FAIL irq_stat_const got=%h want=3", got_rd); end
    // W1C of both bits on the same edge as a new recoverable event
    apb_setup(8'h1C, 1, 32'h3);
    evt_valid = 4'b0001; evt_severity = 16'h0001;
    penable = 1'b1; step();
    evt_valid = '0; psel = 0; penable = 0; step();
    apb(8'h1C, 0, 0, "irq_w1c_race");
    tot++; if (got_rd !== 32'h1) begin bad++; $display("FAIL irq_set_wins got=%h want=1", got_rd); end
  endtask

  task automatic test_errors();
    sel = 0; do_reset();
    apb(8'h24, 0, 0, "unmapped");
    tot++; if ({got_err, got_rd} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL unmapped_const got=%b/%h want=1/0", got_err, got_rd);
    end
    apb(8'h04, 0, 0, "pop_read");
    apb(8'h00, 1, 32'hFF, "status_write");
    apb(8'h04, 1, 0, "pop_empty");
    tot++; if (got_err !== 1'b0) begin bad++; $display("FAIL pop_empty_err got=%b want=0", got_err); end
    apb(8'h00, 0, 0, "status_after_pop");
    apb(8'h20, 0, 0, "tstamp_off");
    // reset while pready is high
    apb_setup(8'h00, 0, 0);
    penable = 1'b1; step();
    tot++; if (pready !== 1'b1) begin bad++; $display("FAIL mid_pready got=%b want=1", pready); end
    rst_n = 1'b0; #1;
    tot++; if (pready !== 1'b0) begin bad++; $display("FAIL mid_reset_pready got=%b want=0", pready); end
    psel = 0; penable = 0;
    @(negedge clk); @(negedge clk);
    model_reset(); rst_n = 1'b1;
    apb(8'h00, 0, 0, "post_mid_reset");
  endtask

  task automatic test_random();
    logic [7:0] addrs [11];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h3C};
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; do_reset();
      rnd_evt = 1;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          int ai; ai = $urandom_range(0, 10);
          if (addrs[ai] == 8'h04) apb(addrs[ai], ($urandom_range(0, 7) != 0), $urandom, "rnd_pop");
          else apb(addrs[ai], ($urandom_range(0, 4) == 0), $urandom, "rnd_apb");
        end else step();
      end
      rnd_evt = 0; evt_valid = '0;
      apb(8'h00, 0, 0, "rnd_status");
      apb(8'h08, 0, 0, "rnd_head");
      apb(8'h14, 0, 0, "rnd_drop");
    end
    sel = 0;
  endtask

  initial begin
    sel = 0; rnd_evt = 0;
    evt_valid = '0; evt_severity = '0; evt_code = '0; evt_data0 = '0; evt_data1 = '0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    model_reset();
    #2;
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_drop();
    test_irq();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
